// File: rtl/cycle_counter.sv
`default_nettype none
// ============================================================================
// Module   : cycle_counter
// Brief    : Global cycle counter with a reset-release delay chain. A hold
//            request ripples through a num_stages_p-deep flop chain whose last
//            stage is the registered, delayed reset. A free-running counter is
//            held at init_val_p while that delayed reset is high and counts
//            one per clock otherwise, timestamping cycles since release.
// Options  : CYCLE_COUNTER_SATURATE_EN - when defined the counter stops at
//            all-ones instead of wrapping to zero.
// Revision : 1.0 - initial release
// ============================================================================
module cycle_counter #(
    parameter int unsigned num_stages_p = 3,
    parameter int unsigned ctr_width_p  = 32,
    parameter int unsigned init_val_p   = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   hold_i,
    output logic                   reset_o,
    output logic [ctr_width_p-1:0] ctr_r_o
);

    // Load value, truncated (or zero-extended) to the counter width.
    localparam logic [ctr_width_p-1:0] C_INIT_VAL = ctr_width_p'(init_val_p);
    localparam logic [ctr_width_p-1:0] C_ONE      = ctr_width_p'(1);

    // ------------------------------------------------------------------------
    // Hold -> reset delay chain. Bit 0 samples hold_i, the top bit is the
    // delayed reset. reset_i fills the whole chain with ones so the delayed
    // reset stays asserted until hold_i has been low for the full depth.
    // ------------------------------------------------------------------------
    logic [num_stages_p-1:0] r_chain;

    generate
        if (num_stages_p == 1) begin : g_chain_single
            // Single-stage chain: the delayed reset is just hold_i registered.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_chain <= 1'b1;
                end else begin
                    r_chain <= hold_i;
                end
            end
        end else begin : g_chain_multi
            // Multi-stage chain: shift hold_i in at the bottom each cycle.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_chain <= '1;
                end else begin
                    r_chain <= {r_chain[num_stages_p-2:0], hold_i};
                end
            end
        end
    endgenerate

    assign reset_o = r_chain[num_stages_p-1];

    // ------------------------------------------------------------------------
    // Counter. The clear is driven by the registered delayed reset, so the
    // first count after release appears one edge after reset_o falls.
    // ------------------------------------------------------------------------
    logic [ctr_width_p-1:0] r_ctr;
    logic [ctr_width_p-1:0] w_ctr_inc;
    logic [ctr_width_p-1:0] w_ctr_next;

    assign w_ctr_inc = r_ctr + C_ONE;

`ifdef CYCLE_COUNTER_SATURATE_EN
    // Next count: stick at all-ones once reached.
    always_comb begin
        w_ctr_next = w_ctr_inc;
        if (r_ctr == '1) begin
            w_ctr_next = r_ctr;
        end
    end
`else
    // Next count: plain modulo-2^width increment, wrapping to zero.
    always_comb begin
        w_ctr_next = w_ctr_inc;
    end
`endif

    // Counter register: load init while either reset is active, else count.
    always_ff @(posedge clk_i) begin
        if (reset_i || reset_o) begin
            r_ctr <= C_INIT_VAL;
        end else begin
            r_ctr <= w_ctr_next;
        end
    end

    assign ctr_r_o = r_ctr;

endmodule
`default_nettype wire

// File: tb/tb_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_counter
// Brief    : Self-checking bench for cycle_counter. Four instances share clock,
//            reset and hold: depth 3 (main), depth 1, depth 5, and a 4-bit
//            counter with init 14 for wrap/saturate behaviour. Expected
//            outputs are pushed to a scoreboard queue as stimulus is applied.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cycle_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b1;

    logic        ro0, ro1, ro2, ro3;
    logic [31:0] c0, c1, c2;
    logic [3:0]  c3;

    always #5 clk = ~clk;

    cycle_counter #(.num_stages_p(3), .ctr_width_p(32), .init_val_p(0)) dut0 (
        .clk_i(clk), .reset_i(rst), .hold_i(hold), .reset_o(ro0), .ctr_r_o(c0));
    cycle_counter #(.num_stages_p(1), .ctr_width_p(32), .init_val_p(0)) dut1 (
        .clk_i(clk), .reset_i(rst), .hold_i(hold), .reset_o(ro1), .ctr_r_o(c1));
    cycle_counter #(.num_stages_p(5), .ctr_width_p(32), .init_val_p(0)) dut2 (
        .clk_i(clk), .reset_i(rst), .hold_i(hold), .reset_o(ro2), .ctr_r_o(c2));
    cycle_counter #(.num_stages_p(3), .ctr_width_p(4), .init_val_p(14)) dut3 (
        .clk_i(clk), .reset_i(rst), .hold_i(hold), .reset_o(ro3), .ctr_r_o(c3));

    logic [3:0]       ro_obs;
    logic [3:0][31:0] ctr_obs;
    assign ro_obs     = {ro3, ro2, ro1, ro0};
    assign ctr_obs[0] = c0;
    assign ctr_obs[1] = c1;
    assign ctr_obs[2] = c2;
    assign ctr_obs[3] = {28'd0, c3};

    typedef struct packed {
        logic [3:0]       ro;
        logic [3:0][31:0] ctr;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state per instance.
    int          m_n[4];
    int          m_w[4];
    logic [31:0] m_init[4];
    logic [7:0]  m_chain[4];
    logic [31:0] m_ctr[4];
    logic [3:0]  wseq[4];

    // Drive one cycle of stimulus, advance the model, push the expectation.
    task automatic apply(input logic h, input logic r);
        exp_t        x;
        logic [31:0] maxv;
        logic        ro_old;
        @(negedge clk);
        hold = h;
        rst  = r;
        for (int d = 0; d < 4; d++) begin
            maxv   = (m_w[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << m_w[d]) - 32'd1);
            ro_old = m_chain[d][m_n[d]-1];
            if (r) begin
                m_ctr[d]   = m_init[d];
                m_chain[d] = 8'hFF;
            end else begin
                if (ro_old) begin
                    m_ctr[d] = m_init[d];
                end else begin
`ifdef CYCLE_COUNTER_SATURATE_EN
                    if (m_ctr[d] != maxv) m_ctr[d] = (m_ctr[d] + 32'd1) & maxv;
`else
                    m_ctr[d] = (m_ctr[d] + 32'd1) & maxv;
`endif
                end
                m_chain[d] = {m_chain[d][6:0], h};
            end
            x.ro[d]  = m_chain[d][m_n[d]-1];
            x.ctr[d] = m_ctr[d];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            apply(1'b1, 1'b1);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro) begin
                errors++;
                $display("FAIL reset_ro cyc=%0d got=%b exp=%b", cyc, ro_obs, e.ro);
            end
            checks++;
            if (ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL reset_ctr cyc=%0d got=%h exp=%h", cyc, ctr_obs, e.ctr);
            end
            checks++;
            if (ro0 !== 1'b1 || c0 !== 32'd0 || c3 !== 4'd14) begin
                errors++;
                $display("FAIL reset_const cyc=%0d got ro0=%b c0=%0d c3=%0d exp 1 0 14", cyc, ro0, c0, c3);
            end
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL release_hold cyc=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", cyc, ro_obs, ctr_obs, e.ro, e.ctr);
            end
        end
        // k counts edges since hold_i was first sampled low.
        for (int k = 1; k <= 14; k++) begin
            apply(1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL release_model k=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", k, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (ro0 !== (k == 2)) begin
                    errors++;
                    $display("FAIL release_ro0 k=%0d got=%b exp=%b", k, ro0, (k == 2));
                end
            end
            if (k == 4 || k == 13) begin
                checks++;
                if (c0 !== ((k == 4) ? 32'd1 : 32'd10)) begin
                    errors++;
                    $display("FAIL release_ctr0 k=%0d got=%0d exp=%0d", k, c0, (k == 4) ? 1 : 10);
                end
            end
            if (k >= 4 && k <= 7) begin
                checks++;
                if (c3 !== wseq[k-4]) begin
                    errors++;
                    $display("FAIL wrap_sat k=%0d got=%0d exp=%0d", k, c3, wseq[k-4]);
                end
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (ro2 !== (k == 4)) begin
                    errors++;
                    $display("FAIL release_ro2 k=%0d got=%b exp=%b", k, ro2, (k == 4));
                end
            end
        end
    endtask

    task automatic run_to(input logic [31:0] target, input string tag);
        int n;
        n = 0;
        while (m_ctr[0] != target && n < 300) begin
            apply(1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL %s_run cyc=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", tag, cyc, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            n++;
        end
        checks++;
        if (c0 !== target) begin
            errors++;
            $display("FAIL %s_reach got=%0d exp=%0d", tag, c0, target);
        end
    endtask

    task automatic test_rehold();
        int pulses;
        run_to(32'd50, "rehold");
        pulses = 0;
        for (int k = 1; k <= 8; k++) begin
            apply((k == 1), 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL rehold_model k=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", k, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            if (ro0 === 1'b1) pulses++;
            checks++;
            if (ro0 !== (k == 3)) begin
                errors++;
                $display("FAIL rehold_ro0 k=%0d got=%b exp=%b", k, ro0, (k == 3));
            end
            if (k == 4 || k == 5) begin
                checks++;
                if (c0 !== 32'(k - 4)) begin
                    errors++;
                    $display("FAIL rehold_ctr0 k=%0d got=%0d exp=%0d", k, c0, k - 4);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL rehold_pulses got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_depth_sweep();
        int rise[4];
        int expd[4];
        expd = '{3, 1, 5, 3};
        rise = '{0, 0, 0, 0};
        for (int k = 1; k <= 8; k++) begin
            apply((k == 1), 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL depth_model k=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", k, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            for (int d = 0; d < 4; d++)
                if (ro_obs[d] === 1'b1 && rise[d] == 0) rise[d] = k;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (rise[d] != expd[d]) begin
                errors++;
                $display("FAIL depth_latency dut%0d got=%0d exp=%0d", d, rise[d], expd[d]);
            end
        end
    endtask

    task automatic test_midrun_reset();
        run_to(32'd100, "midrun");
        apply(1'b0, 1'b1);
        e = sb.pop_front();
        checks++;
        if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
            errors++;
            $display("FAIL midrun_model got ro=%b ctr=%h exp ro=%b ctr=%h", ro_obs, ctr_obs, e.ro, e.ctr);
        end
        checks++;
        if (c0 !== 32'd0 || ro0 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_clear got ro0=%b c0=%0d exp ro0=1 c0=0", ro0, c0);
        end
        for (int k = 1; k <= 5; k++) begin
            apply(1'b0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL midrun_model k=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", k, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            checks++;
            if (ro0 !== (k < 3)) begin
                errors++;
                $display("FAIL midrun_ro0 k=%0d got=%b exp=%b", k, ro0, (k < 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        int highs;
        highs = 0;
        for (int k = 1; k <= 10; k++) begin
            apply((k <= 2), 1'b0);
            e = sb.pop_front();
            checks++;
            if (ro_obs !== e.ro || ctr_obs !== e.ctr) begin
                errors++;
                $display("FAIL b2b_model k=%0d got ro=%b ctr=%h exp ro=%b ctr=%h", k, ro_obs, ctr_obs, e.ro, e.ctr);
            end
            if (ro0 === 1'b1) highs++;
        end
        checks++;
        if (highs != 2) begin
            errors++;
            $display("FAIL b2b_width got=%0d exp=2", highs);
        end
    endtask

    initial begin
        m_n    = '{3, 1, 5, 3};
        m_w    = '{32, 32, 32, 4};
        m_init = '{32'd0, 32'd0, 32'd0, 32'd14};
        for (int d = 0; d < 4; d++) begin
            m_chain[d] = 8'h00;
            m_ctr[d]   = 32'd0;
        end
`ifdef CYCLE_COUNTER_SATURATE_EN
        wseq = '{4'd15, 4'd15, 4'd15, 4'd15};
`else
        wseq = '{4'd15, 4'd0, 4'd1, 4'd2};
`endif
        test_reset();
        test_release();
        test_rehold();
        test_depth_sweep();
        test_midrun_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
